// File: rtl/zeroriscy_mem_arbiter_if.sv
// rtl/zeroriscy_mem_arbiter_if.sv - core fetch/LSU ports and RAM port bundled for the memory arbiter
//
// Purpose
//   Groups every bus signal the arbiter touches: the zero-riscy instruction
//   fetch port, the LSU data port (both req/gnt/rvalid) and the single-port
//   RAM strobe interface. Signal names keep the core-side _i/_o suffixes as
//   seen from the arbiter.
//
// Modports
//   slave  : the arbiter (consumes requests and RAM read data, drives grants,
//            responses, RAM controls and oob_o)
//   master : the environment (core + RAM model)
//
// Parameters
//   ADDR_W : RAM word-address width, must match the arbiter's ADDR_W

interface zeroriscy_mem_arbiter_if #(
    parameter int ADDR_W = 15
);
    // instruction fetch port
    logic              instr_req_i;
    logic [31:0]       instr_addr_i;
    logic              instr_gnt_o;
    logic              instr_rvalid_o;
    logic [31:0]       instr_rdata_o;

    // LSU data port
    logic              data_req_i;
    logic              data_we_i;
    logic [3:0]        data_be_i;
    logic [31:0]       data_addr_i;
    logic [31:0]       data_wdata_i;
    logic              data_gnt_o;
    logic              data_rvalid_o;
    logic [31:0]       data_rdata_o;

    // RAM port
    logic              mem_en_o;
    logic              mem_we_o;
    logic [3:0]        mem_be_o;
    logic [ADDR_W-1:0] mem_addr_o;
    logic [31:0]       mem_wdata_o;
    logic [31:0]       mem_rdata_i;

    // access outside the RAM window
    logic              oob_o;

    modport slave (
        input  instr_req_i, instr_addr_i,
        output instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        input  data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        output data_gnt_o, data_rvalid_o, data_rdata_o,
        output mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        input  mem_rdata_i,
        output oob_o
    );

    modport master (
        output instr_req_i, instr_addr_i,
        input  instr_gnt_o, instr_rvalid_o, instr_rdata_o,
        output data_req_i, data_we_i, data_be_i, data_addr_i, data_wdata_i,
        input  data_gnt_o, data_rvalid_o, data_rdata_o,
        input  mem_en_o, mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o,
        output mem_rdata_i,
        input  oob_o
    );
endinterface

// File: rtl/zeroriscy_mem_arbiter.sv
// rtl/zeroriscy_mem_arbiter.sv - shares one 1-cycle RAM between zero-riscy fetch and LSU ports
//
// Purpose
//   Grants at most one of {instruction fetch, LSU data} per cycle,
//   combinationally from the requests. Data wins a conflict unless it has
//   already been granted MAX_STREAK times in a row while a fetch was waiting,
//   in which case the fetch is forced through. The granted access drives the
//   RAM in the same cycle; the response is returned to the owner one cycle
//   later. Fully pipelined: a new grant can be issued every cycle.
//
// Ports
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; gates every output to 0 while high
//   bus   : zeroriscy_mem_arbiter_if.slave (fetch port, LSU port, RAM port, oob_o)
//
// Parameters
//   ADDR_W     : RAM word-address width (RAM holds 2**ADDR_W 32-bit words)
//   BASE_ADDR  : byte address mapped onto RAM word 0
//   MAX_STREAK : consecutive data grants tolerated while a fetch waits (>= 1)

module zeroriscy_mem_arbiter #(
    parameter int          ADDR_W     = 15,
    parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
    parameter int          MAX_STREAK = 4
) (
    input logic                    clk,
    input logic                    reset,
    zeroriscy_mem_arbiter_if.slave bus
);

    localparam int             SW         = $clog2(MAX_STREAK + 1);
    localparam logic [SW-1:0]  STREAK_MAX = SW'(MAX_STREAK);
    // RAM window size in bytes; 33 bits so ADDR_W up to 30 does not overflow
    localparam logic [32:0]    WIN_BYTES  = 33'd1 << (ADDR_W + 2);

    // response owner encoding
    localparam logic [1:0] OWN_NONE  = 2'd0;
    localparam logic [1:0] OWN_INSTR = 2'd1;
    localparam logic [1:0] OWN_DATA  = 2'd2;

    logic [SW-1:0]     r_streak;
    logic [1:0]        r_owner;
    logic              r_we;
    logic              r_oob;

    logic              w_pick_data;
    logic              w_pick_instr;
    logic              w_gnt_data;
    logic              w_gnt_instr;
    logic              w_gnt_any;
    logic [31:0]       w_addr;
    logic [31:0]       w_off;
    logic              w_in_win;
    logic [ADDR_W-1:0] w_word;
    logic              w_rsp_instr;
    logic              w_rsp_data;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    always_comb begin
        // data yields only when the fetch has waited through a full streak
        w_pick_data  = bus.data_req_i && !(bus.instr_req_i && (r_streak >= STREAK_MAX));
        w_pick_instr = bus.instr_req_i && !w_pick_data;
        w_gnt_data   = w_pick_data  && !reset;
        w_gnt_instr  = w_pick_instr && !reset;
        w_gnt_any    = w_gnt_data || w_gnt_instr;
    end

    // ------------------------------------------------------------------
    // Address decode for the granted access
    // ------------------------------------------------------------------
    always_comb begin
        w_addr   = w_gnt_data ? bus.data_addr_i : bus.instr_addr_i;
        // unsigned wrap: addresses below BASE_ADDR become huge offsets and
        // therefore fall outside the window
        w_off    = w_addr - BASE_ADDR;
        w_in_win = ({1'b0, w_off} < WIN_BYTES);
        w_word   = w_off[ADDR_W+1:2];
    end

    // ------------------------------------------------------------------
    // RAM drive (same cycle as the grant)
    // ------------------------------------------------------------------
    always_comb begin
        bus.instr_gnt_o = w_gnt_instr;
        bus.data_gnt_o  = w_gnt_data;
        bus.mem_en_o    = w_gnt_any && w_in_win;
        bus.mem_we_o    = w_gnt_data && bus.data_we_i && w_in_win;
        bus.mem_be_o    = w_gnt_data  ? bus.data_be_i :
                          w_gnt_instr ? 4'hF : 4'h0;
        bus.mem_addr_o  = w_gnt_any  ? w_word : '0;
        bus.mem_wdata_o = w_gnt_data ? bus.data_wdata_i : 32'h0;
        bus.oob_o       = w_gnt_any && !w_in_win;
    end

    // ------------------------------------------------------------------
    // Starvation counter: counts data grants that overtook a waiting fetch
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_streak <= '0;
        end else if (!bus.instr_req_i || w_gnt_instr) begin
            r_streak <= '0;
        end else if (w_gnt_data && (r_streak < STREAK_MAX)) begin
            r_streak <= r_streak + SW'(1);
        end
    end

    // ------------------------------------------------------------------
    // Response tracking: one outstanding slot, refilled every cycle
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner <= OWN_NONE;
            r_we    <= 1'b0;
            r_oob   <= 1'b0;
        end else begin
            r_owner <= w_gnt_data  ? OWN_DATA  :
                       w_gnt_instr ? OWN_INSTR : OWN_NONE;
            r_we    <= w_gnt_data && bus.data_we_i;
            r_oob   <= w_gnt_any && !w_in_win;
        end
    end

    // ------------------------------------------------------------------
    // Response outputs; rdata is 0 for writes, out-of-window and non-owners
    // ------------------------------------------------------------------
    always_comb begin
        w_rsp_instr        = (r_owner == OWN_INSTR) && !reset;
        w_rsp_data         = (r_owner == OWN_DATA)  && !reset;
        bus.instr_rvalid_o = w_rsp_instr;
        bus.data_rvalid_o  = w_rsp_data;
        bus.instr_rdata_o  = (w_rsp_instr && !r_oob) ? bus.mem_rdata_i : 32'h0;
        bus.data_rdata_o   = (w_rsp_data && !r_oob && !r_we) ? bus.mem_rdata_i : 32'h0;
    end

endmodule
